uart_rx: RTL and testbench

- Serial receiver for the 8-bit UART. It consumes the 16x oversampling `s_tick` strobe from the baud rate generator and deserialises the `rx` line (8N1 by default, LSB first).
- It presents each received byte on `dout` with a one-clock `rx_done_tick` strobe and a `frame_err` flag.
- It sits between the pad and the RX FIFO/host logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// uart_tx imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_e;

  localparam int UART_DBIT    = 8;
  localparam int UART_OVS     = 16;
  localparam int UART_SB_TICK = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous pad inputs (RX, CTS, ...).
// RST_VAL sets the level both flops take during reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data shift, stop-bit check with framing error and break hold-off.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OVS     = UART_OVS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output state_e          state_o
);

  localparam int SW = $clog2(max_int(OVS, SB_TICK));
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] b_d;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign b_d = {rx_s, b_q[DBIT-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          // A start bit must still be low half a bit later, else it was a glitch.
          if (s_tick) begin
            if (s_q == S_HALF) begin
              s_q <= '0;
              if (rx_s) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_BIT) begin
              s_q <= '0;
              b_q <= b_d;
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_STOP) begin
              s_q     <= '0;
              dout_q  <= b_q;
              done_q  <= 1'b1;
              ferr_q  <= !rx_s;
              // A low stop bit may be a break: wait for idle before re-arming.
              state_q <= rx_s ? IDLE : BRK;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        BRK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8N1 instance plus a DBIT=7, SB_TICK=32
// instance, s_tick every 4 clk, 64 clk per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       rx;
  logic       rx2;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  state_e     state_o;
  logic [6:0] dout2;
  logic       rx_done_tick2;
  logic       frame_err2;
  state_e     state_o2;

  logic [1:0] tick_cnt;
  int         cyc;
  int         checks;
  int         errors;
  int         pulses;
  int         pulses2;
  int         pulse_cyc;
  int         pulse_cyc2;
  int         start_cyc;
  logic [7:0] cap_dout;
  logic       cap_ferr;
  logic [6:0] cap_dout2;
  logic       cap_ferr2;
  int         p0;
  int         p2;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .state_o      (state_o)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32), .OVS(16)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx2),
    .dout         (dout2),
    .rx_done_tick (rx_done_tick2),
    .frame_err    (frame_err2),
    .state_o      (state_o2)
  );

  // Clock, cycle counter and 1-in-4 tick source.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc      = 0;
    tick_cnt = 2'd0;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tick_cnt <= tick_cnt + 2'd1;
  end

  assign s_tick = (tick_cnt == 2'd3);

  // Pulse monitor: one-clk strobes are seen by exactly one negedge.
  initial begin
    pulses  = 0;
    pulses2 = 0;
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      pulses++;
      cap_dout  = dout;
      cap_ferr  = frame_err;
      pulse_cyc = cyc;
    end
    if (rx_done_tick2) begin
      pulses2++;
      cap_dout2  = dout2;
      cap_ferr2  = frame_err2;
      pulse_cyc2 = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int sel, input logic val);
    if (sel == 0) rx = val;
    else rx2 = val;
  endtask

  // One frame: start bit, nbits LSB first, stop level held for nstop bit periods.
  task automatic send(input int sel, input logic [8:0] data, input int nbits,
                      input logic stop_val, input int nstop);
    @(negedge clk);
    start_cyc = cyc;
    drive_line(sel, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive_line(sel, data[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    drive_line(sel, stop_val);
    repeat (nstop * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    rx2    = 1'b1;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    rst = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // 0xA5 8N1, pulse 9.5 bit periods (608 clk) after the start edge
    p0 = pulses;
    send(0, 9'h0A5, 8, 1'b1, 1);
    check("a5_count", 32'(pulses - p0), 32'd1);
    check("a5_dout", 32'(cap_dout), 32'hA5);
    check("a5_ferr", 32'(cap_ferr), 32'h0);
    check("a5_latency_ok", 32'((pulse_cyc - start_cyc >= 604) && (pulse_cyc - start_cyc <= 612)), 32'h1);
    check("a5_hold", 32'(dout), 32'hA5);

    // Glitch: low for 3 ticks only
    p0 = pulses;
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("glitch_count", 32'(pulses - p0), 32'd0);
    check("glitch_state", 32'(state_o), 32'(IDLE));
    send(0, 9'h03C, 8, 1'b1, 1);
    check("post_glitch_count", 32'(pulses - p0), 32'd1);
    check("post_glitch_dout", 32'(cap_dout), 32'h3C);
    check("post_glitch_ferr", 32'(cap_ferr), 32'h0);

    // Framing error followed by a 40-bit break
    p0 = pulses;
    send(0, 9'h03C, 8, 1'b0, 1);
    repeat (40 * BIT_CLK) @(negedge clk);
    check("brk_count", 32'(pulses - p0), 32'd1);
    check("brk_dout", 32'(cap_dout), 32'h3C);
    check("brk_ferr", 32'(cap_ferr), 32'h1);
    check("brk_ferr_hold", 32'(frame_err), 32'h1);
    check("brk_state", 32'(state_o), 32'(BRK));
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("brk_release_count", 32'(pulses - p0), 32'd1);
    check("brk_release_state", 32'(state_o), 32'(IDLE));
    send(0, 9'h081, 8, 1'b1, 1);
    check("after_brk_dout", 32'(cap_dout), 32'h81);
    check("after_brk_ferr", 32'(cap_ferr), 32'h0);

    // Back-to-back frames: 0x00 then 0xFF with no idle gap
    p0 = pulses;
    send(0, 9'h000, 8, 1'b1, 1);
    check("b2b0_count", 32'(pulses - p0), 32'd1);
    check("b2b0_dout", 32'(cap_dout), 32'h00);
    check("b2b0_ferr", 32'(cap_ferr), 32'h0);
    send(0, 9'h0FF, 8, 1'b1, 1);
    check("b2b1_count", 32'(pulses - p0), 32'd2);
    check("b2b1_dout", 32'(cap_dout), 32'hFF);
    check("b2b1_ferr", 32'(cap_ferr), 32'h0);
    repeat (BIT_CLK) @(negedge clk);

    // Reset during data bit 4 of 0xF3 (bits 4..7 high, so no false start)
    p0 = pulses;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_state", 32'(state_o), 32'(IDLE));
    repeat (30 + 4 * BIT_CLK) @(negedge clk);
    check("midrst_count", 32'(pulses - p0), 32'd0);
    check("midrst_dout_hold", 32'(dout), 32'h0);
    send(0, 9'h05A, 8, 1'b1, 1);
    check("after_rst_count", 32'(pulses - p0), 32'd1);
    check("after_rst_dout", 32'(cap_dout), 32'h5A);

    // DBIT=7, 2 stop bits on the second instance
    p0 = pulses;
    p2 = pulses2;
    send(1, 9'h055, 7, 1'b1, 2);
    check("v7_count", 32'(pulses2 - p2), 32'd1);
    check("v7_dout", 32'(cap_dout2), 32'h55);
    check("v7_ferr", 32'(cap_ferr2), 32'h0);
    check("v7_in_stop2", 32'((pulse_cyc2 - start_cyc >= 576) && (pulse_cyc2 - start_cyc < 640)), 32'h1);
    check("v7_latency_ok", 32'((pulse_cyc2 - start_cyc >= 604) && (pulse_cyc2 - start_cyc <= 612)), 32'h1);
    check("v7_main_quiet", 32'(pulses - p0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
